// File: rtl/alu_writeback.sv
// alu_writeback: one-entry writeback stage committing ALU results into a 4x8 register file and Z/C flags
module alu_writeback (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_wb_valid,
    output logic       o_wb_ready,
    input  logic [2:0] i_wb_mode,
    input  logic [1:0] i_wb_dest,
    input  logic [7:0] i_wb_result,
    input  logic       i_wb_zero,
    input  logic       i_wb_carry,
    input  logic       i_stall_in,
    input  logic [1:0] i_rd_a_addr,
    input  logic [1:0] i_rd_b_addr,
    output logic [7:0] o_rd_a_data,
    output logic [7:0] o_rd_b_data,
    output logic       o_flag_z,
    output logic       o_flag_c,
    output logic       o_commit_valid,
    output logic [1:0] o_commit_dest,
    output logic [7:0] o_commit_data,
    output logic [7:0] o_retired_count
);
    logic       r_s1_valid;
    logic [2:0] r_s1_mode;
    logic [1:0] r_s1_dest;
    logic [7:0] r_s1_result;
    logic       r_s1_zero;
    logic       r_s1_carry;
    logic [7:0] r_regs [4];
    logic       r_flag_z;
    logic       r_flag_c;
    logic [7:0] r_retired;
    logic       w_commit;
    logic       w_accept;
    logic       w_wr_reg;
    logic       w_wr_z;
    logic       w_wr_c;
    logic       w_z_next;

    // in reset the stage advertises ready and never commits, even before s1 is cleared
    assign o_wb_ready     = !rst_n || !r_s1_valid || !i_stall_in;
    assign w_commit       = rst_n && r_s1_valid && !i_stall_in;
    assign w_accept       = i_wb_valid && o_wb_ready;
    // add/sub/and/or/xor write the register file; compare and 110/111 only retire
    assign w_wr_reg       = w_commit && (r_s1_mode != 3'd2) && (r_s1_mode < 3'd6);
    assign w_wr_z         = w_commit && (r_s1_mode < 3'd6);
    assign w_wr_c         = w_commit && (r_s1_mode < 3'd3);
    // only compare trusts the ALU zero output; every other mode derives Z from the result
    assign w_z_next       = (r_s1_mode == 3'd2) ? r_s1_zero : (r_s1_result == 8'h00);
    assign o_rd_a_data    = (w_wr_reg && r_s1_dest == i_rd_a_addr) ? r_s1_result : r_regs[i_rd_a_addr];
    assign o_rd_b_data    = (w_wr_reg && r_s1_dest == i_rd_b_addr) ? r_s1_result : r_regs[i_rd_b_addr];
    assign o_flag_z       = r_flag_z;
    assign o_flag_c       = r_flag_c;
    assign o_commit_valid = w_commit;
    assign o_commit_dest  = r_s1_dest;
    assign o_commit_data  = r_s1_result;
    assign o_retired_count = r_retired;

    // holding register: reload on accept (possibly while committing), empty on a bare commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_mode   <= '0;
            r_s1_dest   <= '0;
            r_s1_result <= '0;
            r_s1_zero   <= 1'b0;
            r_s1_carry  <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid  <= 1'b1;
            r_s1_mode   <= i_wb_mode;
            r_s1_dest   <= i_wb_dest;
            r_s1_result <= i_wb_result;
            r_s1_zero   <= i_wb_zero;
            r_s1_carry  <= i_wb_carry;
        end else if (w_commit) begin
            r_s1_valid  <= 1'b0;
        end
    end

    // register file write on register-writing commits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_regs[i] <= 8'h00;
        end else if (w_wr_reg) begin
            r_regs[r_s1_dest] <= r_s1_result;
        end
    end

    // architectural flags and the retire counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flag_z  <= 1'b0;
            r_flag_c  <= 1'b0;
            r_retired <= 8'h00;
        end else begin
            if (w_wr_z) r_flag_z <= w_z_next;
            if (w_wr_c) r_flag_c <= r_s1_carry;
            if (w_commit) r_retired <= r_retired + 8'd1;
        end
    end
endmodule
